// File: rtl/ved_mult_seq.sv
// Sequential Urdhva-Tiryagbhyam multiplier: four half-width partial products on one
// shared HxH Vedic core, accumulated over four cycles, with signed mode and valid/ready.

module ved_mult_core #(
  parameter int H = 32
) (
  input  logic [H-1:0]   x,
  input  logic [H-1:0]   y,
  output logic [2*H-1:0] p
);
  // Column sums never exceed H and carries never exceed H, so col stays below 2H+1.
  localparam int CW = $clog2(H) + 2;

  logic [CW-1:0] col;
  logic [CW-1:0] carry;

  // Vertically-and-crosswise: column k sums every x[i]&y[j] with i+j==k, then ripples carry up.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch can be inferred.
    p     = '0;
    col   = '0;
    carry = '0;
    for (int k = 0; k < 2*H-1; k++) begin
      col = carry;
      for (int i = 0; i < H; i++) begin
        if ((k - i >= 0) && (k - i < H)) col = col + CW'(x[i] & y[k-i]);
      end
      p[k]  = col[0];
      carry = col >> 1;
    end
    p[2*H-1] = carry[0];
  end
endmodule

module ved_mult_seq #(
  parameter int WIDTH  = 64,
  parameter int SIGNED = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy
);
  localparam int H  = WIDTH / 2;
  localparam int W2 = 2 * WIDTH;
  localparam logic SGN_EN = (SIGNED != 0);

  typedef enum logic [2:0] {IDLE, PP0, PP1, PP2, PP3, DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  ma;
  logic [WIDTH-1:0]  mb;
  logic              neg;
  logic [W2-1:0]     acc;

  logic              sm;
  logic              accept;
  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;
  logic [H-1:0]      core_x;
  logic [H-1:0]      core_y;
  logic [WIDTH-1:0]  pp;
  logic [W2-1:0]     pp_ext;
  logic [W2-1:0]     sum_final;

  assign sm       = signed_mode & SGN_EN;
  // in_ready is forced low while reset is held, even though state already reads IDLE.
  assign in_ready = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept   = in_valid & in_ready;
  assign busy     = (state != IDLE);

  // Negating -2^(W-1) wraps back to itself, which read as unsigned is the correct magnitude.
  assign a_mag = (sm & a[WIDTH-1]) ? -a : a;
  assign b_mag = (sm & b[WIDTH-1]) ? -b : b;

  always_comb begin
    core_x = ma[H-1:0];
    core_y = mb[H-1:0];
    case (state)
      PP1:     begin core_x = ma[WIDTH-1:H]; core_y = mb[H-1:0];     end
      PP2:     begin core_x = ma[H-1:0];     core_y = mb[WIDTH-1:H]; end
      PP3:     begin core_x = ma[WIDTH-1:H]; core_y = mb[WIDTH-1:H]; end
      default: begin core_x = ma[H-1:0];     core_y = mb[H-1:0];     end
    endcase
  end

  ved_mult_core #(.H(H)) u_core (
    .x (core_x),
    .y (core_y),
    .p (pp)
  );

  assign pp_ext    = W2'(pp);
  assign sum_final = acc + (pp_ext << WIDTH);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every state register is cleared by reset so an aborted product leaves no trace.
    if (!rst_n) begin
      state     <= IDLE;
      ma        <= '0;
      mb        <= '0;
      neg       <= 1'b0;
      acc       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      ma        <= a_mag;
      mb        <= b_mag;
      neg       <= sm & (a[WIDTH-1] ^ b[WIDTH-1]);
      acc       <= '0;
      out_valid <= 1'b0;
      state     <= PP0;
    end else begin
      case (state)
        PP0: begin
          acc   <= acc + pp_ext;
          state <= PP1;
        end
        PP1: begin
          acc   <= acc + (pp_ext << H);
          state <= PP2;
        end
        PP2: begin
          acc   <= acc + (pp_ext << H);
          state <= PP3;
        end
        PP3: begin
          result    <= neg ? -sum_final : sum_final;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ved_mult_seq.sv
// Directed and randomised checks of ved_mult_seq (WIDTH=64, SIGNED=1) against hand values
// and a behavioural product model.

module tb_ved_mult_seq;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  a;
  logic [63:0]  b;
  logic         signed_mode;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] result;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  ved_mult_seq #(.WIDTH(64), .SIGNED(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model(input logic [63:0] x, input logic [63:0] y,
                                          input logic s);
    if (s) model = $signed({{64{x[63]}}, x}) * $signed({{64{y[63]}}, y});
    else   model = {64'b0, x} * {64'b0, y};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands and returns #1 after the accept edge.
  task automatic send(input logic [63:0] ta, input logic [63:0] tb2, input logic tsm,
                      input string tag);
    int n = 0;
    in_valid    = 1'b1;
    a           = ta;
    b           = tb2;
    signed_mode = tsm;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_in_ready"}, 128'(in_ready), 128'(1'b1));
    tick();
    in_valid    = 1'b0;
    a           = {$urandom(), $urandom()};
    b           = {$urandom(), $urandom()};
    signed_mode = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic run_op(input logic [63:0] ta, input logic [63:0] tb2, input logic tsm,
                        input logic [127:0] exp, input string tag, input int hold);
    int lat;
    send(ta, tb2, tsm, tag);
    wait_result(lat);
    check({tag, "_latency"}, 128'(lat), 128'(4));
    check({tag, "_result"}, result, exp);
    repeat (hold) tick();
    if (hold > 0) check({tag, "_held"}, result, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drop"}, 128'(out_valid), 128'(1'b0));
  endtask

  typedef struct {
    logic [63:0]  x;
    logic [63:0]  y;
    logic         s;
    logic [127:0] p;
    string        tag;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat;
    logic [63:0] ra, rb;
    logic        rs;

    vecs[0] = '{64'd5,    64'd6,    1'b0, 128'd30,      "u_5x6"};
    vecs[1] = '{64'd255,  64'd250,  1'b0, 128'd63750,   "u_255x250"};
    vecs[2] = '{64'd1000, 64'd1000, 1'b0, 128'd1000000, "u_1000x1000"};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, "u_max"};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFB, 64'd6, 1'b1,
                128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFE2, "s_m5x6"};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 128'd1, "s_m1xm1"};
    vecs[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
                128'h4000_0000_0000_0000_0000_0000_0000_0000, "s_min_sq"};
    vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0,
                128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE, "u_topbit"};
    vecs[8] = '{64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1,
                128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB, "s_7xm3"};

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; signed_mode = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready",  128'(in_ready),  128'(1'b0));
    check("rst_out_valid", 128'(out_valid), 128'(1'b0));
    check("rst_result",    result,          128'd0);
    check("rst_busy",      128'(busy),      128'(1'b0));
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", 128'(in_ready), 128'(1'b1));

    foreach (vecs[i]) run_op(vecs[i].x, vecs[i].y, vecs[i].s, vecs[i].p, vecs[i].tag, 0);

    // Backpressure, then a back-to-back accept on the handshake edge.
    send(64'd3, 64'd4, 1'b0, "bp");
    wait_result(lat);
    check("bp_latency", 128'(lat), 128'(4));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_out_valid", 128'(out_valid), 128'(1'b1));
      check("bp_result",    result,          128'd12);
      check("bp_in_ready",  128'(in_ready),  128'(1'b0));
    end
    in_valid = 1'b1; a = 64'd9; b = 64'd7; signed_mode = 1'b0; out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 128'(in_ready), 128'(1'b1));
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_drop", 128'(out_valid), 128'(1'b0));
    check("b2b_busy", 128'(busy),      128'(1'b1));
    wait_result(lat);
    check("b2b_latency", 128'(lat), 128'(4));
    check("b2b_result",  result,    128'd63);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in PP2 discards the in-flight product.
    send(64'd100, 64'd100, 1'b0, "rst_mid");
    tick();
    tick();
    check("mid_busy", 128'(busy), 128'(1'b1));
    rst_n = 1'b0;
    #1;
    check("mid_out_valid", 128'(out_valid), 128'(1'b0));
    check("mid_result",    result,          128'd0);
    check("mid_busy_rst",  128'(busy),      128'(1'b0));
    check("mid_in_ready",  128'(in_ready),  128'(1'b0));
    #3 rst_n = 1'b1;
    tick();
    check("mid_no_result", 128'(out_valid), 128'(1'b0));
    run_op(64'd15, 64'd15, 1'b0, 128'd225, "post_rst", 0);

    // Random operands and modes with random idle and stall cycles.
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) ra[63:32] = 32'hFFFF_FFFF;
      run_op(ra, rb, rs, model(ra, rb, rs), "rand", int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
